spi_cmd_seq: RTL

Parameterised SPI command sequencer. It holds a loadable table of up to DEPTH command frames, each a DATA_W-bit word plus a byte count. It plays the frames out in order to the SPI master through a start/busy/finished handshake. It sits between the configuration/bring-up logic and the SPI master, and supports a power-up auto-start delay, an inter-frame gap, an optional loop mode and abort.

---
 rtl/spi_cmd_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: loadable table of SPI command frames played out in order to an
// SPI master through a start/busy/finished handshake. Supports a power-up
// auto-start delay, an inter-frame gap, optional loop mode and abort.
module spi_cmd_seq #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned BYTE_W     = 3,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned INIT_WAIT  = 50,
    parameter int unsigned AUTO_START = 1,
    parameter int unsigned GAP_CYC    = 4,
    parameter int unsigned LOOP_EN    = 0,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [BYTE_W-1:0] cfg_bytes,
    input  logic [AW:0]       seq_len,
    input  logic              run,
    input  logic              abort,
    input  logic              spi_busy,
    input  logic              spi_finished,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    output logic [BYTE_W-1:0] spi_bytes,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [AW-1:0]     seq_idx
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    // One counter serves both the power-up wait and the inter-frame gap.
    localparam int unsigned CNT_MAX = (INIT_WAIT > GAP_CYC) ? INIT_WAIT : GAP_CYC;
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'((INIT_WAIT == 0) ? 0 : INIT_WAIT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
    localparam state_t        RESET_ST  = (AUTO_START != 0) ? S_INIT : S_IDLE;

    logic [DATA_W-1:0] tbl_data_q  [DEPTH];
    logic [BYTE_W-1:0] tbl_bytes_q [DEPTH];

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       len_q, len_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BYTE_W-1:0] bytes_q, bytes_d;

    logic              tbl_we;
    logic [AW:0]       run_len;
    logic              frame_last;
    logic              go;

    assign tbl_we     = cfg_we && !busy_q;
    assign run_len    = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
    assign frame_last = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));

    // Command table: writable only while no sequence is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_data_q[i]  <= '0;
                tbl_bytes_q[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl_data_q[cfg_addr]  <= cfg_data;
            tbl_bytes_q[cfg_addr] <= cfg_bytes;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_ST;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            done_q  <= done_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
        end
    end

    // Next-state logic; the frame word is reloaded whenever the index moves so
    // it stays stable from ISSUE entry until the frame finishes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        go      = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    if (cnt_q >= INIT_LAST) go = 1'b1;
                    else                    cnt_d = cnt_q + CW'(1);
                end
                S_IDLE: begin
                    if (run) go = 1'b1;
                end
                S_ISSUE: begin
                    if (!spi_busy) begin
                        start_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (spi_finished) begin
                        cnt_d = '0;
                        if (frame_last && (LOOP_EN == 0)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            if (frame_last) begin
                                done_d = 1'b1;
                                idx_d  = '0;
                            end else begin
                                idx_d  = idx_q + AW'(1);
                            end
                            state_d = (GAP_CYC == 0) ? S_ISSUE : S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q >= GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Auto-start completion behaves exactly like a run sampled in IDLE.
            if (go) begin
                len_d = run_len;
                idx_d = '0;
                cnt_d = '0;
                if (run_len == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
        end

        data_d  = data_q;
        bytes_d = bytes_q;
        if (!abort && (go || (idx_d != idx_q) || (state_q == S_WAIT && spi_finished
                                                  && busy_d))) begin
            data_d  = tbl_data_q[idx_d];
            bytes_d = tbl_bytes_q[idx_d];
        end
    end

    assign spi_start = start_q;
    assign spi_data  = data_q;
    assign spi_bytes = bytes_q;
    assign seq_busy  = busy_q;
    assign seq_done  = done_q;
    assign seq_idx   = idx_q;

endmodule
